// File: rtl/rf_wb_sched_if.sv
// Write-back scheduler bus: ALU result path, load-return path, RF write port
// and decode-stage hazard query, bundled for rf_wb_sched.
interface rf_wb_sched_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [1:0]  ld_memop;
  logic        rf_wr;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [1:0]  rf_memop;
  logic [4:0]  rs_a;
  logic [4:0]  rs_b;
  logic        haz_a;
  logic        haz_b;
  logic        busy;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_memop, rs_a, rs_b,
    input  alu_stall, ld_ready, rf_wr, rf_a3, rf_wd, rf_memop, haz_a, haz_b, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_memop, rs_a, rs_b,
    output alu_stall, ld_ready, rf_wr, rf_a3, rf_wd, rf_memop, haz_a, haz_b, busy
  );
endinterface

// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler: ALU vs. queued load returns with starvation
// guard and RAW hazard flags. Optional macro RF_WB_BYPASS_EN lets loads skip the FIFO.
module rf_wb_sched #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input logic         clk,
  input logic         rst,
  rf_wb_sched_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  memop;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic [3:0]         starv_q, starv_d;
  logic               rf_wr_q, rf_wr_d;
  logic [4:0]         rf_a3_q, rf_a3_d;
  logic [31:0]        rf_wd_q, rf_wd_d;
  logic [1:0]         rf_memop_q, rf_memop_d;
  logic               out_ld_q, out_ld_d;

  logic               fifo_empty_s;
  logic               force_s;
  logic               alu_req_s;
  logic               alu_win_s;
  logic               fifo_win_s;
  logic               ld_acc_s;
  logic               byp_s;
  logic               enq_s;
  entry_t             head_s;
  logic [PTR_W-1:0]   off_s;
  logic [DEPTH-1:0]   hit_a_s, hit_b_s;
  logic               out_hit_a_s, out_hit_b_s;

  // Arbitration: forced drain > ALU (rd!=0) > FIFO head; bypass only when nothing else wins.
  always_comb begin
    fifo_empty_s = (count_q == CNT_W'(0));
    force_s      = (starv_q == 4'(MAX_WAIT)) && !fifo_empty_s;
    alu_req_s    = bus.alu_valid && (bus.alu_rd != 5'd0);
    alu_win_s    = alu_req_s && !force_s;
    fifo_win_s   = !fifo_empty_s && !alu_win_s;
    ld_acc_s     = bus.ld_valid && !full_q;
`ifdef RF_WB_BYPASS_EN
    byp_s        = ld_acc_s && (bus.ld_rd != 5'd0) && fifo_empty_s && !alu_win_s;
`else
    byp_s        = 1'b0;
`endif
    enq_s        = ld_acc_s && (bus.ld_rd != 5'd0) && !byp_s;
    head_s       = mem_q[rd_ptr_q];
  end

  // Next-state for FIFO bookkeeping, starvation counter and the write-port register.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starv_d    = starv_q;
    rf_wr_d    = 1'b0;
    rf_a3_d    = rf_a3_q;
    rf_wd_d    = rf_wd_q;
    rf_memop_d = rf_memop_q;
    out_ld_d   = 1'b0;

    if (enq_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (fifo_win_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({enq_s, fifo_win_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(DEPTH));

    if (fifo_win_s || fifo_empty_s) begin
      starv_d = 4'd0;
    end else if (alu_win_s && (starv_q != 4'(MAX_WAIT))) begin
      starv_d = starv_q + 4'd1;
    end else begin
      starv_d = starv_q;
    end

    if (fifo_win_s) begin
      rf_wr_d    = 1'b1;
      rf_a3_d    = head_s.rd;
      rf_wd_d    = head_s.data;
      rf_memop_d = head_s.memop;
      out_ld_d   = 1'b1;
    end else if (alu_win_s) begin
      rf_wr_d    = 1'b1;
      rf_a3_d    = bus.alu_rd;
      rf_wd_d    = bus.alu_data;
      rf_memop_d = 2'b10;
      out_ld_d   = 1'b0;
    end else if (byp_s) begin
      rf_wr_d    = 1'b1;
      rf_a3_d    = bus.ld_rd;
      rf_wd_d    = bus.ld_data;
      rf_memop_d = bus.ld_memop;
      out_ld_d   = 1'b1;
    end else begin
      rf_wr_d    = 1'b0;
      out_ld_d   = 1'b0;
    end
  end

  // Hazard match over live FIFO slots (offset from read pointer below count) plus the output register.
  always_comb begin
    hit_a_s = '0;
    hit_b_s = '0;
    off_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s      = PTR_W'(i) - rd_ptr_q;
      hit_a_s[i] = ({1'b0, off_s} < count_q) && (mem_q[i].rd == bus.rs_a);
      hit_b_s[i] = ({1'b0, off_s} < count_q) && (mem_q[i].rd == bus.rs_b);
    end
    out_hit_a_s = rf_wr_q && out_ld_q && (rf_a3_q == bus.rs_a);
    out_hit_b_s = rf_wr_q && out_ld_q && (rf_a3_q == bus.rs_b);
  end

  // State registers; reset drops queued loads and the in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      starv_q    <= 4'd0;
      rf_wr_q    <= 1'b0;
      rf_a3_q    <= 5'd0;
      rf_wd_q    <= 32'd0;
      rf_memop_q <= 2'b10;
      out_ld_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      starv_q    <= starv_d;
      rf_wr_q    <= rf_wr_d;
      rf_a3_q    <= rf_a3_d;
      rf_wd_q    <= rf_wd_d;
      rf_memop_q <= rf_memop_d;
      out_ld_q   <= out_ld_d;
    end
  end

  // FIFO storage; slots outside the live window are masked by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_q[wr_ptr_q] <= '{rd: bus.ld_rd, data: bus.ld_data, memop: bus.ld_memop};
    end
  end

  assign bus.alu_stall = force_s && alu_req_s;
  assign bus.ld_ready  = !full_q;
  assign bus.rf_wr     = rf_wr_q;
  assign bus.rf_a3     = rf_a3_q;
  assign bus.rf_wd     = rf_wd_q;
  assign bus.rf_memop  = rf_memop_q;
  assign bus.haz_a     = (bus.rs_a != 5'd0) && ((|hit_a_s) || out_hit_a_s);
  assign bus.haz_b     = (bus.rs_b != 5'd0) && ((|hit_b_s) || out_hit_b_s);
  assign bus.busy      = !fifo_empty_s || rf_wr_q;
endmodule
